core_exu_issue_ctrl: RTL and testbench

- Issue controller between IDU and EXU. Gates the IDU→EXU valid/ready handshake on RAW/WAW register hazards, an in-flight instruction limit, and unresolved control transfers.
- Tracks destination registers from issue until WBU writeback using a busy scoreboard.
- Serialises jal/jalr/branch. Raises a one-cycle IFU flush when EXU reports a taken control transfer.

---
 rtl/core_ctrl_pkg.sv | 11 +
 rtl/core_issue_scoreboard.sv | 40 ++++
 rtl/core_exu_issue_ctrl.sv | 106 ++++++++++
 tb/tb_core_exu_issue_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the IDU->EXU issue controller.
package core_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_BR_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } ctrl_state_e;
endpackage

// File: rtl/core_issue_scoreboard.sv
// GPR busy scoreboard: a bit per register from issue until writeback; x0 never busy.
module core_issue_scoreboard
  import core_ctrl_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0] rs1_idx,
  input  logic [REG_W-1:0] rs2_idx,
  input  logic [REG_W-1:0] rd_idx,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rd_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_comb begin
    busy_nxt = busy;
    if (clr_en && clr_idx != REG_ZERO) busy_nxt[clr_idx] = 1'b0;
    if (set_en && set_idx != REG_ZERO) busy_nxt[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign rs1_busy = (rs1_idx != REG_ZERO) && busy[rs1_idx];
  assign rs2_busy = (rs2_idx != REG_ZERO) && busy[rs2_idx];
  assign rd_busy  = (rd_idx  != REG_ZERO) && busy[rd_idx];

endmodule

// File: rtl/core_exu_issue_ctrl.sv
// Issue controller: gates IDU->EXU on hazards, in-flight limit and unresolved branches.
//   state     | meaning
//   S_RUN     | normal issue, subject to hazard and in-flight limit
//   S_BR_WAIT | control transfer in EXU, nothing issues until it resolves
//   S_FLUSH   | taken transfer: one-cycle IFU flush, wrong-path IDU op dropped
module core_exu_issue_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 2,
  parameter int NREG         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idu_tx_valid,
  output logic             idu_tx_ready,
  input  logic [REG_W-1:0] idu_rd_idx,
  input  logic             idu_rd_wen,
  input  logic [REG_W-1:0] idu_rs1_idx,
  input  logic             idu_rs1_ren,
  input  logic [REG_W-1:0] idu_rs2_idx,
  input  logic             idu_rs2_ren,
  input  logic             idu_is_ctrl,
  output logic             exu_rx_valid,
  input  logic             exu_rx_ready,
  input  logic             exu_tx_fire,
  input  logic             exu_tx_bc_done,
  input  logic             exu_tx_bc_en,
  input  logic             wbu_wb_valid,
  input  logic             wbu_wb_wen,
  input  logic [REG_W-1:0] wbu_wb_rd_idx,
  output logic             ifu_flush,
  output logic             ctrl_stall,
  output logic [CNT_W-1:0] ctrl_inflight,
  output logic             ctrl_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  ctrl_state_e state, state_nxt;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        hazard, permit, issue;

  core_issue_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue && idu_rd_wen),
    .set_idx  (idu_rd_idx),
    .clr_en   (wbu_wb_valid && wbu_wb_wen),
    .clr_idx  (wbu_wb_rd_idx),
    .rs1_idx  (idu_rs1_idx),
    .rs2_idx  (idu_rs2_idx),
    .rd_idx   (idu_rd_idx),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  assign hazard = (idu_rs1_ren && rs1_busy) || (idu_rs2_ren && rs2_busy) ||
                  (idu_rd_wen && rd_busy);
  assign permit = (state == S_RUN) && !hazard && (ctrl_inflight < MAX_CNT);
  assign issue  = idu_tx_valid && exu_rx_ready && permit;
  assign ctrl_stall = idu_tx_valid && exu_rx_ready && !permit;

  always_comb begin
    state_nxt    = state;
    exu_rx_valid = 1'b0;
    idu_tx_ready = 1'b0;
    case (state)
      S_RUN: begin
        exu_rx_valid = idu_tx_valid && permit;
        idu_tx_ready = exu_rx_ready && permit;
        if (issue && idu_is_ctrl) state_nxt = S_BR_WAIT;
      end
      S_BR_WAIT: begin
        if (exu_tx_fire && exu_tx_bc_done)
          state_nxt = exu_tx_bc_en ? S_FLUSH : S_RUN;
      end
      // Accept and discard whatever IDU holds: it is on the wrong path.
      S_FLUSH: begin
        idu_tx_ready = 1'b1;
        state_nxt    = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_RUN;
      ifu_flush     <= 1'b0;
      ctrl_inflight <= '0;
      ctrl_err      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ifu_flush <= (state_nxt == S_FLUSH);
      case ({issue, wbu_wb_valid})
        2'b10:   ctrl_inflight <= ctrl_inflight + 1'b1;
        2'b01:   if (ctrl_inflight != '0) ctrl_inflight <= ctrl_inflight - 1'b1;
        default: ctrl_inflight <= ctrl_inflight;
      endcase
      if (wbu_wb_valid && ctrl_inflight == '0) ctrl_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_exu_issue_ctrl.sv
// Directed bench for core_exu_issue_ctrl with hand-computed expectations.
module tb_core_exu_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       idu_tx_valid, idu_tx_ready;
  logic [4:0] idu_rd_idx, idu_rs1_idx, idu_rs2_idx;
  logic       idu_rd_wen, idu_rs1_ren, idu_rs2_ren, idu_is_ctrl;
  logic       exu_rx_valid, exu_rx_ready;
  logic       exu_tx_fire, exu_tx_bc_done, exu_tx_bc_en;
  logic       wbu_wb_valid, wbu_wb_wen;
  logic [4:0] wbu_wb_rd_idx;
  logic       ifu_flush, ctrl_stall, ctrl_err;
  logic [1:0] ctrl_inflight;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_exu_issue_ctrl #(.MAX_INFLIGHT(2), .CNT_W(2), .NREG(32)) u_dut (
    .clk(clk), .rst(rst),
    .idu_tx_valid(idu_tx_valid), .idu_tx_ready(idu_tx_ready),
    .idu_rd_idx(idu_rd_idx), .idu_rd_wen(idu_rd_wen),
    .idu_rs1_idx(idu_rs1_idx), .idu_rs1_ren(idu_rs1_ren),
    .idu_rs2_idx(idu_rs2_idx), .idu_rs2_ren(idu_rs2_ren),
    .idu_is_ctrl(idu_is_ctrl),
    .exu_rx_valid(exu_rx_valid), .exu_rx_ready(exu_rx_ready),
    .exu_tx_fire(exu_tx_fire), .exu_tx_bc_done(exu_tx_bc_done), .exu_tx_bc_en(exu_tx_bc_en),
    .wbu_wb_valid(wbu_wb_valid), .wbu_wb_wen(wbu_wb_wen), .wbu_wb_rd_idx(wbu_wb_rd_idx),
    .ifu_flush(ifu_flush), .ctrl_stall(ctrl_stall),
    .ctrl_inflight(ctrl_inflight), .ctrl_err(ctrl_err)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge, then drive.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idu(input logic v, input logic [4:0] rd, input logic wen,
                     input logic [4:0] rs1, input logic r1, input logic [4:0] rs2,
                     input logic r2, input logic ctrl);
    idu_tx_valid = v;  idu_rd_idx = rd;   idu_rd_wen = wen;
    idu_rs1_idx = rs1; idu_rs1_ren = r1;  idu_rs2_idx = rs2;
    idu_rs2_ren = r2;  idu_is_ctrl = ctrl;
  endtask

  task automatic wbu(input logic v, input logic wen, input logic [4:0] rd);
    wbu_wb_valid = v; wbu_wb_wen = wen; wbu_wb_rd_idx = rd;
  endtask

  task automatic exu(input logic fire, input logic done, input logic en);
    exu_tx_fire = fire; exu_tx_bc_done = done; exu_tx_bc_en = en;
  endtask

  initial begin
    rst = 1'b1;
    exu_rx_ready = 1'b1;
    idu(0, 0, 0, 0, 0, 0, 0, 0);
    wbu(0, 0, 0);
    exu(0, 0, 0);
    #12;
    check_eq("rst_inflight", ctrl_inflight, 0);
    check_eq("rst_flush", ifu_flush, 0);
    check_eq("rst_err", ctrl_err, 0);
    check_eq("rst_rx_valid", exu_rx_valid, 0);
    step(); rst = 1'b0;

    // RAW stall on x5
    step(); idu(1, 5, 1, 1, 1, 0, 0, 0); #1;
    check_eq("raw_first_valid", exu_rx_valid, 1);
    check_eq("raw_first_ready", idu_tx_ready, 1);
    step(); idu(1, 6, 1, 5, 1, 1, 1, 0); #1;
    check_eq("raw_stall", ctrl_stall, 1);
    check_eq("raw_held_valid", exu_rx_valid, 0);
    check_eq("raw_inflight1", ctrl_inflight, 1);
    step(); wbu(1, 1, 5); #1;
    check_eq("raw_no_bypass", ctrl_stall, 1);
    step(); wbu(0, 0, 0); #1;
    check_eq("raw_issue_after_wb", exu_rx_valid, 1);
    check_eq("raw_stall_clear", ctrl_stall, 0);
    check_eq("raw_inflight0", ctrl_inflight, 0);
    step(); idu(0, 0, 0, 0, 0, 0, 0, 0); wbu(1, 1, 6); #1;
    check_eq("raw_inflight_after", ctrl_inflight, 1);

    // x0 writes and the in-flight limit
    step(); wbu(0, 0, 0); idu(1, 0, 1, 0, 0, 0, 0, 0); #1;
    check_eq("x0_a_valid", exu_rx_valid, 1);
    check_eq("x0_a_inflight", ctrl_inflight, 0);
    step(); #1;
    check_eq("x0_b_valid", exu_rx_valid, 1);
    step(); #1;
    check_eq("lim_stall", ctrl_stall, 1);
    check_eq("lim_valid", exu_rx_valid, 0);
    check_eq("lim_inflight2", ctrl_inflight, 2);
    check_eq("x0_never_busy", u_dut.u_sb.busy[0], 0);
    step(); wbu(1, 0, 0); #1;
    check_eq("lim_retire_same_cycle", ctrl_stall, 1);
    step(); wbu(0, 0, 0); #1;
    check_eq("lim_third_issues", exu_rx_valid, 1);
    check_eq("lim_inflight1", ctrl_inflight, 1);
    step(); idu(0, 0, 0, 0, 0, 0, 0, 0); wbu(1, 0, 0); #1;
    check_eq("lim_inflight_back2", ctrl_inflight, 2);
    step(); #1;
    check_eq("lim_drain1", ctrl_inflight, 1);
    step(); wbu(0, 0, 0); #1;
    check_eq("lim_drain0", ctrl_inflight, 0);

    // Not-taken branch
    step(); idu(1, 0, 0, 1, 1, 0, 0, 1); #1;
    check_eq("nt_br_issue", exu_rx_valid, 1);
    step(); idu(1, 7, 1, 2, 1, 0, 0, 0); exu(0, 1, 0); #1;
    check_eq("nt_held_stall", ctrl_stall, 1);
    check_eq("nt_held_valid", exu_rx_valid, 0);
    step(); exu(1, 1, 0); wbu(1, 0, 0); #1;
    check_eq("nt_stale_done_ignored", exu_rx_valid, 0);
    check_eq("nt_resolve_cycle_valid", exu_rx_valid, 0);
    step(); exu(0, 0, 0); wbu(0, 0, 0); #1;
    check_eq("nt_next_issues", exu_rx_valid, 1);
    check_eq("nt_no_flush", ifu_flush, 0);
    check_eq("nt_inflight0", ctrl_inflight, 0);
    step(); idu(0, 0, 0, 0, 0, 0, 0, 0); wbu(1, 1, 7); #1;
    check_eq("nt_inflight1", ctrl_inflight, 1);
    check_eq("nt_flush_still0", ifu_flush, 0);

    // Taken jal
    step(); wbu(0, 0, 0); idu(1, 1, 1, 0, 0, 0, 0, 1); #1;
    check_eq("tk_jal_issue", exu_rx_valid, 1);
    step(); idu(1, 8, 1, 0, 0, 0, 0, 0); exu(1, 1, 1); #1;
    check_eq("tk_held_valid", exu_rx_valid, 0);
    check_eq("tk_flush_pre", ifu_flush, 0);
    step(); exu(0, 0, 0); #1;
    check_eq("tk_flush", ifu_flush, 1);
    check_eq("tk_drop_ready", idu_tx_ready, 1);
    check_eq("tk_drop_valid", exu_rx_valid, 0);
    check_eq("tk_inflight1", ctrl_inflight, 1);
    step(); idu(0, 0, 0, 0, 0, 0, 0, 0); wbu(1, 1, 1); #1;
    check_eq("tk_flush_one_cycle", ifu_flush, 0);
    check_eq("tk_inflight_after_drop", ctrl_inflight, 1);
    check_eq("tk_dropped_not_busy", u_dut.u_sb.busy[8], 0);

    // Simultaneous issue and retire, then retire underflow
    step(); wbu(0, 0, 0); idu(1, 9, 1, 0, 0, 0, 0, 0); #1;
    check_eq("sim_inflight0", ctrl_inflight, 0);
    check_eq("sim_a_valid", exu_rx_valid, 1);
    step(); idu(1, 10, 1, 0, 0, 0, 0, 0); wbu(1, 1, 9); #1;
    check_eq("sim_b_valid", exu_rx_valid, 1);
    step(); idu(0, 0, 0, 0, 0, 0, 0, 0); wbu(1, 1, 10); #1;
    check_eq("sim_inflight_unchanged", ctrl_inflight, 1);
    step(); #1;
    check_eq("uf_err_pre", ctrl_err, 0);
    step(); wbu(0, 0, 0); #1;
    check_eq("uf_err_set", ctrl_err, 1);
    check_eq("uf_inflight0", ctrl_inflight, 0);
    step(); #1;
    check_eq("uf_err_sticky", ctrl_err, 1);

    // Reset while waiting on a branch with x5 busy and two in flight
    idu(1, 5, 1, 0, 0, 0, 0, 0); #1;
    step(); idu(1, 0, 0, 1, 1, 0, 0, 1); #1;
    check_eq("mr_branch_issue", exu_rx_valid, 1);
    step(); idu(1, 12, 1, 5, 1, 0, 0, 0); #1;
    check_eq("mr_inflight2", ctrl_inflight, 2);
    check_eq("mr_stall", ctrl_stall, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("mr_inflight_cleared", ctrl_inflight, 0);
    check_eq("mr_err_cleared", ctrl_err, 0);
    check_eq("mr_flush0", ifu_flush, 0);
    step(); rst = 1'b0; #1;
    check_eq("mr_issue_after_rst", exu_rx_valid, 1);
    check_eq("mr_no_stall", ctrl_stall, 0);
    step(); idu(0, 0, 0, 0, 0, 0, 0, 0); #1;
    check_eq("mr_inflight1", ctrl_inflight, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
